// File: rtl/dense_seq_ctrl.sv
// rtl/dense_seq_ctrl.sv - dense layer sequencer: streams 8-lane chunks into the dot unit, accumulates, adds bias, writes neurons
`ifndef N_LEN
`define N_LEN 16
`endif

module dense_seq_ctrl #(
    parameter int DATA_WIDTH = `N_LEN,
    parameter int N_IN       = 64,
    parameter int N_OUT      = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAC_LAT    = 3,
    localparam int CHUNKS    = N_IN / 8,
    localparam int CW        = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    localparam int OW        = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int WW        = (N_OUT * CHUNKS > 1) ? $clog2(N_OUT * CHUNKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [CW-1:0]         x_addr,
    output logic [WW-1:0]         w_addr,
    output logic [OW-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0] b_q,
    input  logic [DATA_WIDTH-1:0] dot_q,
    output logic                  out_we,
    output logic [OW-1:0]         out_addr,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int D = MEM_LAT + MAC_LAT;
    localparam int BD = MAC_LAT - 1;
    localparam logic [CW-1:0] K_LAST = CW'(CHUNKS - 1);
    localparam logic [OW-1:0] J_LAST = OW'(N_OUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_en_q, rd_en_d;
    logic [CW-1:0]         k_q, k_d;
    logic [OW-1:0]         j_q, j_d;
    logic [WW-1:0]         w_q, w_d;
    logic                  tv_q [D];
    logic                  tv_d [D];
    logic                  tf_q [D];
    logic                  tf_d [D];
    logic                  tl_q [D];
    logic                  tl_d [D];
    logic [OW-1:0]         tj_q [D];
    logic [OW-1:0]         tj_d [D];
    logic [DATA_WIDTH-1:0] bias_q [BD];
    logic [DATA_WIDTH-1:0] bias_d [BD];
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  out_we_q, out_we_d;
    logic [OW-1:0]         out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                  issue_go;
    logic [CW-1:0]         nk;
    logic [OW-1:0]         nj;
    logic [WW-1:0]         nw;
    logic [DATA_WIDTH-1:0] base;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rd_en_d  = 1'b0;
        k_d      = k_q;
        j_d      = j_q;
        w_d      = w_q;
        issue_go = 1'b0;
        nk       = '0;
        nj       = '0;
        nw       = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    issue_go = 1'b1;
                    state_d  = ISSUE;
                    busy_d   = 1'b1;
                end
            end
            ISSUE: begin
                if (k_q == K_LAST && j_q == J_LAST) begin
                    state_d = DRAIN;
                    k_d     = '0;
                    j_d     = '0;
                    w_d     = '0;
                end else begin
                    issue_go = 1'b1;
                    nw       = w_q + 1'b1;
                    if (k_q == K_LAST) begin
                        nk = '0;
                        nj = j_q + 1'b1;
                    end else begin
                        nk = k_q + 1'b1;
                        nj = j_q;
                    end
                end
            end
            DRAIN: begin
                if (out_we_q && out_addr_q == J_LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (issue_go) begin
            rd_en_d = 1'b1;
            k_d     = nk;
            j_d     = nj;
            w_d     = nw;
        end

        // Tag enters the pipe on the same edge that launches the read it describes.
        tv_d[0] = issue_go;
        tf_d[0] = (nk == '0);
        tl_d[0] = (nk == K_LAST);
        tj_d[0] = nj;
        for (int i = 1; i < D; i++) begin
            tv_d[i] = tv_q[i-1];
            tf_d[i] = tf_q[i-1];
            tl_d[i] = tl_q[i-1];
            tj_d[i] = tj_q[i-1];
        end

        // Bias is only latched for a neuron's first chunk, so neighbours never share a word.
        bias_d[0] = (tv_q[MEM_LAT] && tf_q[MEM_LAT]) ? b_q : '0;
        for (int i = 1; i < BD; i++) begin
            bias_d[i] = bias_q[i-1];
        end

        acc_d      = acc_q;
        out_we_d   = 1'b0;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        base       = tf_q[D-1] ? bias_q[BD-1] : acc_q;
        if (tv_q[D-1]) begin
            acc_d = base + dot_q;
            if (tl_q[D-1]) begin
                out_we_d   = 1'b1;
                out_addr_d = tj_q[D-1];
                out_data_d = base + dot_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            k_q        <= '0;
            j_q        <= '0;
            w_q        <= '0;
            acc_q      <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            for (int i = 0; i < D; i++) begin
                tv_q[i] <= 1'b0;
                tf_q[i] <= 1'b0;
                tl_q[i] <= 1'b0;
                tj_q[i] <= '0;
            end
            for (int i = 0; i < BD; i++) begin
                bias_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            k_q        <= k_d;
            j_q        <= j_d;
            w_q        <= w_d;
            acc_q      <= acc_d;
            out_we_q   <= out_we_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            for (int i = 0; i < D; i++) begin
                tv_q[i] <= tv_d[i];
                tf_q[i] <= tf_d[i];
                tl_q[i] <= tl_d[i];
                tj_q[i] <= tj_d[i];
            end
            for (int i = 0; i < BD; i++) begin
                bias_q[i] <= bias_d[i];
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_en    = rd_en_q;
    assign x_addr   = k_q;
    assign w_addr   = w_q;
    assign b_addr   = j_q;
    assign out_we   = out_we_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// tb/tb_dense_seq_ctrl.sv - self-checking bench for dense_seq_ctrl
module tb_dense_seq_ctrl;

    localparam int DW    = 16;
    localparam int N_OUT = 32;
    localparam int CH    = 8;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    always #5 clk = ~clk;

    logic          busy, done, rd_en, out_we;
    logic [2:0]    x_addr;
    logic [7:0]    w_addr;
    logic [4:0]    b_addr, out_addr;
    logic [DW-1:0] b_q, dot_q, out_data;

    logic          busy2, done2, rd_en2, out_we2;
    logic [0:0]    x_addr2;
    logic [1:0]    w_addr2, b_addr2, out_addr2;
    logic [DW-1:0] b_q2, dot_q2, out_data2;

    dense_seq_ctrl #(.DATA_WIDTH(DW), .N_IN(64), .N_OUT(32), .MEM_LAT(1), .MAC_LAT(3)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
        .x_addr(x_addr), .w_addr(w_addr), .b_addr(b_addr), .b_q(b_q), .dot_q(dot_q),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    dense_seq_ctrl #(.DATA_WIDTH(DW), .N_IN(8), .N_OUT(4), .MEM_LAT(1), .MAC_LAT(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .rd_en(rd_en2),
        .x_addr(x_addr2), .w_addr(w_addr2), .b_addr(b_addr2), .b_q(b_q2), .dot_q(dot_q2),
        .out_we(out_we2), .out_addr(out_addr2), .out_data(out_data2)
    );

    assign b_q2   = 16'hFFFE;
    assign dot_q2 = 16'd5;

    // Memory read register doubles as the first dot-unit stage.
    logic [DW-1:0] dmem [256];
    logic [DW-1:0] bmem [32];
    logic [DW-1:0] d1, d2;
    always @(posedge clk) begin
        b_q   <= rd_en ? bmem[b_addr] : 16'hDEAD;
        d1    <= rd_en ? dmem[w_addr] : 16'hBEEF;
        d2    <= d1;
        dot_q <= d2;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    bit            mon = 1'b0;
    int            t0 = 0;
    int            mc;
    int            wq_cyc [$];
    int            wq_addr [$];
    logic [DW-1:0] wq_data [$];
    int            done_cyc [$];
    int            rd_cnt, addr_bad, busy_cnt, busy_bad, consec;
    bit            prev_we;

    always @(negedge clk) begin
        if (mon) begin
            mc = cyc - t0;
            if (out_we) begin
                wq_cyc.push_back(mc);
                wq_addr.push_back(int'(out_addr));
                wq_data.push_back(out_data);
            end
            if (done) done_cyc.push_back(mc);
            if (rd_en) begin
                if (int'(w_addr) != rd_cnt || int'(x_addr) != rd_cnt % CH ||
                    int'(b_addr) != rd_cnt / CH || mc != rd_cnt + 1)
                    addr_bad++;
                rd_cnt++;
            end
            if (busy) begin
                busy_cnt++;
                if (mc < 1 || mc > N_OUT * CH + LAT) busy_bad++;
            end
            if (out_we && prev_we) consec++;
            prev_we = out_we;
        end
    end

    bit            mon2 = 1'b0;
    int            t2 = 0;
    int            w2_cyc [$];
    int            w2_addr [$];
    logic [DW-1:0] w2_data [$];
    int            done2_cyc [$];
    always @(negedge clk) begin
        if (mon2) begin
            if (out_we2) begin
                w2_cyc.push_back(cyc - t2);
                w2_addr.push_back(int'(out_addr2));
                w2_data.push_back(out_data2);
            end
            if (done2) done2_cyc.push_back(cyc - t2);
        end
    end

    function automatic logic [DW-1:0] ref_neuron(input int j);
        int s = 0;
        for (int k = 0; k < CH; k++) s += int'(dmem[j*CH + k]);
        s += int'(bmem[j]);
        return DW'(s);
    endfunction

    task automatic clear_mon();
        wq_cyc.delete(); wq_addr.delete(); wq_data.delete(); done_cyc.delete();
        rd_cnt = 0; addr_bad = 0; busy_cnt = 0; busy_bad = 0; consec = 0; prev_we = 1'b0;
    endtask

    task automatic run_and_check(input string nm, input bit repulse);
        clear_mon();
        mon = 1'b1;
        @(negedge clk);
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 600 && done_cyc.size() == 0; i++) begin
            @(negedge clk);
            start = repulse && ((cyc - t0) == 50 || (cyc - t0) == 100);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        mon = 1'b0;
        chk({nm, " done_count"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk({nm, " done_cycle"}, done_cyc[0], N_OUT*CH + LAT + 1);
        chk({nm, " write_count"}, wq_cyc.size(), N_OUT);
        for (int j = 0; j < wq_cyc.size() && j < N_OUT; j++) begin
            chk($sformatf("%s addr[%0d]", nm, j), wq_addr[j], j);
            chk($sformatf("%s data[%0d]", nm, j), wq_data[j], ref_neuron(j));
            chk($sformatf("%s wcyc[%0d]", nm, j), wq_cyc[j], (j+1)*CH + LAT);
        end
        chk({nm, " rd_count"}, rd_cnt, N_OUT*CH);
        chk({nm, " rd_addr_errs"}, addr_bad, 0);
        chk({nm, " busy_cycles"}, busy_cnt, N_OUT*CH + LAT);
        chk({nm, " busy_window_errs"}, busy_bad, 0);
        chk({nm, " back_to_back_we"}, consec, 0);
    endtask

    typedef struct {
        logic [DW-1:0] dot;
        logic [DW-1:0] bias_base;
        logic [DW-1:0] exp0;
        logic [DW-1:0] exp31;
        bit            repulse;
    } vec_t;

    task automatic fill(input logic [DW-1:0] dot, input logic [DW-1:0] base);
        for (int i = 0; i < 256; i++) dmem[i] = dot;
        for (int j = 0; j < 32; j++) bmem[j] = base + DW'(j);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        tbl[0] = '{16'h0001, 16'h0000, 16'h0008, 16'h0027, 1'b0};
        tbl[1] = '{16'h4000, 16'h0000, 16'h0000, 16'h001F, 1'b1};
        tbl[2] = '{16'hFFFF, 16'h0100, 16'h00F8, 16'h0117, 1'b0};
        tbl[3] = '{16'h2000, 16'h7FF0, 16'h7FF0, 16'h800F, 1'b0};

        fill(16'h0001, 16'h0000);
        repeat (3) @(negedge clk);
        chk("reset ctrl", {busy, done, rd_en, out_we}, 0);
        chk("reset addr", {x_addr, w_addr, b_addr, out_addr}, 0);
        chk("reset data", out_data, 0);
        chk("reset dut2", {busy2, done2, rd_en2, out_we2}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            fill(tbl[r].dot, tbl[r].bias_base);
            run_and_check($sformatf("row%0d", r), tbl[r].repulse);
            if (wq_data.size() == N_OUT) begin
                chk($sformatf("row%0d exp0", r), wq_data[0], tbl[r].exp0);
                chk($sformatf("row%0d exp31", r), wq_data[N_OUT-1], tbl[r].exp31);
            end
        end

        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 256; i++) dmem[i] = DW'($urandom);
            for (int j = 0; j < 32; j++) bmem[j] = DW'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_and_check($sformatf("rand%0d", n), n[0]);
        end

        // Abort mid-run, then confirm the block is silent and restarts cleanly.
        fill(16'h0001, 16'h0000);
        clear_mon();
        mon = 1'b1;
        @(negedge clk);
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc - t0 < 100) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort ctrl", {busy, done, rd_en, out_we}, 0);
        chk("abort addr", {x_addr, w_addr, b_addr, out_addr}, 0);
        chk("abort data", out_data, 0);
        clear_mon();
        while (cyc - t0 < 102) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        mon = 1'b0;
        chk("abort writes_after", wq_cyc.size(), 0);
        chk("abort done_after", done_cyc.size(), 0);
        run_and_check("restart", 1'b0);

        // CHUNKS=1 instance: one write per cycle is legal.
        @(negedge clk);
        t2 = cyc;
        mon2 = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (20) @(negedge clk);
        mon2 = 1'b0;
        chk("c1 write_count", w2_cyc.size(), 4);
        for (int j = 0; j < w2_cyc.size() && j < 4; j++) begin
            chk($sformatf("c1 wcyc[%0d]", j), w2_cyc[j], 5 + j);
            chk($sformatf("c1 addr[%0d]", j), w2_addr[j], j);
            chk($sformatf("c1 data[%0d]", j), w2_data[j], 3);
        end
        chk("c1 done_count", done2_cyc.size(), 1);
        if (done2_cyc.size() > 0) chk("c1 done_cycle", done2_cyc[0], 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
